// File: rtl/draw_sequencer.sv
// draw_sequencer: per-frame draw master. Clears the screen to a background
// colour, then grants each active sprite plotter slot in turn and forwards
// the granted slot's pixels to a single registered VGA write port.
module draw_sequencer #(
  parameter int          N_SPRITES  = 4,
  parameter int          SCREEN_W   = 320,
  parameter int          SCREEN_H   = 240,
  parameter logic [2:0]  BG_COLOUR  = 3'b000,
  parameter bit          CLEAR_EN   = 1'b1,
  parameter bit          TRANSP_EN  = 1'b0,
  parameter logic [2:0]  TRANSP_COL = 3'b000,
  parameter int          TIMEOUT    = 1023
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   frame_tick,
  input  logic [N_SPRITES-1:0]   sprite_active,
  input  logic [9*N_SPRITES-1:0] sprite_x,
  input  logic [8*N_SPRITES-1:0] sprite_y,
  input  logic [3*N_SPRITES-1:0] sprite_colour,
  input  logic [N_SPRITES-1:0]   sprite_done,
  output logic [N_SPRITES-1:0]   sprite_enable,
  output logic [8:0]             vga_x,
  output logic [7:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   error
);

  // idx must be able to hold N_SPRITES itself (the "all slots visited" value)
  localparam int IDXW  = $clog2(N_SPRITES + 1);
  localparam int TLOG  = $clog2(TIMEOUT + 1);
  localparam int TW    = (TLOG > 10) ? TLOG : 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SELECT,
    S_SPRITE,
    S_FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [8:0]      cx_q, cx_d;
  logic [7:0]      cy_q, cy_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            error_q, error_d;
  logic [8:0]      vga_x_q, vga_x_d;
  logic [7:0]      vga_y_q, vga_y_d;
  logic [2:0]      vga_colour_q, vga_colour_d;
  logic            vga_plot_q, vga_plot_d;

  // Signals of the slot currently addressed by idx
  logic            slot_active;
  logic            slot_done;
  logic [8:0]      slot_x;
  logic [7:0]      slot_y;
  logic [2:0]      slot_colour;

  // Select the addressed slot's inputs; idx==N_SPRITES selects nothing
  always_comb begin
    slot_active = 1'b0;
    slot_done   = 1'b0;
    slot_x      = '0;
    slot_y      = '0;
    slot_colour = '0;
    for (int i = 0; i < N_SPRITES; i++) begin
      if (idx_q == IDXW'(i)) begin
        slot_active = sprite_active[i];
        slot_done   = sprite_done[i];
        slot_x      = sprite_x[9*i +: 9];
        slot_y      = sprite_y[8*i +: 8];
        slot_colour = sprite_colour[3*i +: 3];
      end
    end
  end

  // Grant is a pure function of the registered state and slot index
  generate
    for (genvar gi = 0; gi < N_SPRITES; gi++) begin : g_enable
      assign sprite_enable[gi] = (state_q == S_SPRITE) && (idx_q == IDXW'(gi));
    end
  endgenerate

  // Next-state, counters, sticky error and VGA port staging
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    timer_d      = timer_q;
    error_d      = error_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;

    // A new frame cannot start while one is in progress; flag the overrun
    if (frame_tick && (state_q != S_IDLE)) begin
      error_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          idx_d = '0;
          cx_d  = '0;
          cy_d  = '0;
          if (CLEAR_EN) begin
            state_d = S_CLEAR;
          end else begin
            state_d = S_SELECT;
          end
        end
      end

      S_CLEAR: begin
        vga_plot_d   = 1'b1;
        vga_x_d      = cx_q;
        vga_y_d      = cy_q;
        vga_colour_d = BG_COLOUR;
        if (cx_q == 9'(SCREEN_W - 1)) begin
          cx_d = '0;
          if (cy_q == 8'(SCREEN_H - 1)) begin
            cy_d    = '0;
            state_d = S_SELECT;
          end else begin
            cy_d = cy_q + 8'd1;
          end
        end else begin
          cx_d = cx_q + 9'd1;
        end
      end

      S_SELECT: begin
        if (idx_q == IDXW'(N_SPRITES)) begin
          state_d = S_FINISH;
        end else if (slot_active) begin
          timer_d = '0;
          state_d = S_SPRITE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      S_SPRITE: begin
        vga_x_d      = slot_x;
        vga_y_d      = slot_y;
        vga_colour_d = slot_colour;
        vga_plot_d   = !(TRANSP_EN && (slot_colour == TRANSP_COL));
        if (slot_done) begin
          idx_d   = idx_q + IDXW'(1);
          state_d = S_SELECT;
        end else if (timer_q == TW'(TIMEOUT)) begin
          // Slot held the grant too long: abort it and move on
          error_d = 1'b1;
          idx_d   = idx_q + IDXW'(1);
          state_d = S_SELECT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      timer_q      <= '0;
      error_q      <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      timer_q      <= timer_d;
      error_q      <= error_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_FINISH);
  assign error      = error_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: directed bench for draw_sequencer with a behavioural
// sprite plotter model and a pixel scoreboard on the VGA write port.
module tb_draw_sequencer;

  localparam int         N  = 3;
  localparam int         W  = 4;
  localparam int         H  = 2;
  localparam int         K  = 5;
  localparam logic [2:0] BG = 3'b010;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           frame_tick = 1'b0;
  logic [N-1:0]   sprite_active = '0;
  logic [9*N-1:0] sprite_x = '0;
  logic [8*N-1:0] sprite_y = '0;
  logic [3*N-1:0] sprite_colour = '0;
  logic [N-1:0]   model_done = '0;
  logic [N-1:0]   spur_done = '0;
  logic [N-1:0]   sprite_done;
  logic [N-1:0]   sprite_enable;
  logic [8:0]     vga_x;
  logic [7:0]     vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot;
  logic           busy;
  logic           frame_done;
  logic           error;

  assign sprite_done = model_done | spur_done;

  draw_sequencer #(
    .N_SPRITES (N),
    .SCREEN_W  (W),
    .SCREEN_H  (H),
    .BG_COLOUR (BG),
    .CLEAR_EN  (1'b1),
    .TRANSP_EN (1'b1),
    .TRANSP_COL(3'b000),
    .TIMEOUT   (15)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .frame_tick   (frame_tick),
    .sprite_active(sprite_active),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .sprite_colour(sprite_colour),
    .sprite_done  (sprite_done),
    .sprite_enable(sprite_enable),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_plot     (vga_plot),
    .busy         (busy),
    .frame_done   (frame_done),
    .error        (error)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [19:0] exp_q[$];
  int          n_plots = 0;
  int          en_cycles[N];
  int          cnt[N];
  logic [N-1:0] prev_done = '0;
  logic [N-1:0] never_done = '0;
  logic [N-1:0] alt_col = '0;
  logic [8:0]  px;
  logic [7:0]  py;
  logic [2:0]  pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Plotter model: drives a pixel stream while granted, pulses done K cycles after grant
  always @(negedge clk) begin
    if (!resetn) begin
      model_done = '0;
      prev_done  = '0;
      for (int i = 0; i < N; i++) cnt[i] = 0;
    end else begin
      check("enable_onehot", 32'($onehot0(sprite_enable)), 1);
      for (int i = 0; i < N; i++) begin
        if (prev_done[i]) check($sformatf("enable_drop_slot%0d", i), sprite_enable[i], 0);
        if (sprite_enable[i]) begin
          px = 9'(100 + 40 * i + cnt[i]);
          py = 8'(20 * i + cnt[i]);
          pc = alt_col[i] ? (((cnt[i] % 2) == 1) ? 3'b101 : 3'b000) : 3'(i + 1);
          sprite_x[9*i +: 9]      = px;
          sprite_y[8*i +: 8]      = py;
          sprite_colour[3*i +: 3] = pc;
          if (pc != 3'b000) exp_q.push_back({px, py, pc});
          en_cycles[i]++;
          model_done[i] = (cnt[i] == K) && !never_done[i];
          cnt[i]++;
        end else begin
          cnt[i]        = 0;
          model_done[i] = 1'b0;
        end
        prev_done[i] = model_done[i];
      end
    end
  end

  // Scoreboard: every VGA write must match the oldest expected pixel
  always @(negedge clk) begin
    if (resetn && vga_plot) begin
      n_plots++;
      if (exp_q.size() == 0) check("plot_unexpected", vga_plot, 0);
      else check("vga_pixel_xyc", {vga_x, vga_y, vga_colour}, exp_q.pop_front());
    end
  end

  task automatic push_clear();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back({9'(x), 8'(y), BG});
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) en_cycles[i] = 0;
  endtask

  // Run one frame; cyc = cycles from the tick until frame_done is seen
  task automatic run_frame(input logic [N-1:0] act, input bit tick_mid, input bit spur_mid,
                           output int cyc);
    bit tdone = 0;
    bit sdone = 0;
    sprite_active = act;
    @(negedge clk);
    push_clear();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    cyc = 1;
    while (!frame_done && cyc < 400) begin
      spur_done  = '0;
      frame_tick = 1'b0;
      if (tick_mid && !tdone && (sprite_enable != '0)) begin
        frame_tick = 1'b1;
        tdone = 1;
      end
      if (spur_mid && !sdone && sprite_enable[0]) begin
        spur_done = 3'b100;
        sdone = 1;
      end
      @(negedge clk);
      cyc++;
    end
    spur_done  = '0;
    frame_tick = 1'b0;
    check("frame_done_seen", frame_done, 1);
  endtask

  int cyc;
  int p0;

  initial begin
    clear_counts();
    // Power-on reset
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_vga_plot", vga_plot, 0);
    check("rst_enable", sprite_enable, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_error", error, 0);
    check("rst_vga_xyc", {vga_x, vga_y, vga_colour}, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Reset in the middle of CLEAR
    sprite_active = '0;
    push_clear();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_in_clear", busy, 1);
    resetn = 1'b0;
    exp_q.delete();
    #1;
    check("midclr_rst_busy", busy, 0);
    check("midclr_rst_plot", vga_plot, 0);
    check("midclr_rst_enable", sprite_enable, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Frame with no active slots: clear restarts at (0,0), frame_done 13 cycles after tick
    p0 = n_plots;
    run_frame(3'b000, 0, 0, cyc);
    check("empty_frame_latency", cyc, 13);
    check("empty_frame_plots", n_plots - p0, 8);
    @(negedge clk);
    check("frame_done_one_cycle", frame_done, 0);
    check("idle_after_frame", busy, 0);
    check("empty_queue_drained", exp_q.size(), 0);

    // Slots 0 and 2 active, spurious done on slot 2 while slot 0 holds the grant
    clear_counts();
    run_frame(3'b101, 0, 1, cyc);
    check("s101_latency", cyc, 25);
    check("s101_en0_cycles", en_cycles[0], 6);
    check("s101_en1_cycles", en_cycles[1], 0);
    check("s101_en2_cycles", en_cycles[2], 6);
    check("s101_error", error, 0);
    @(negedge clk);
    check("s101_queue_drained", exp_q.size(), 0);

    // Transparency: slot 0 alternates 000/101, only 101 pixels are written
    clear_counts();
    alt_col = 3'b001;
    p0 = n_plots;
    run_frame(3'b001, 0, 0, cyc);
    check("transp_latency", cyc, 19);
    @(negedge clk);
    check("transp_plots", n_plots - p0, 8 + 3);
    check("transp_queue_drained", exp_q.size(), 0);
    alt_col = '0;

    // frame_tick during SPRITE: error set, frame otherwise unchanged
    clear_counts();
    run_frame(3'b101, 1, 0, cyc);
    check("midtick_latency", cyc, 25);
    check("midtick_error", error, 1);
    check("midtick_en0_cycles", en_cycles[0], 6);
    check("midtick_en2_cycles", en_cycles[2], 6);
    repeat (5) @(negedge clk);
    check("midtick_no_restart", busy, 0);
    check("midtick_queue_drained", exp_q.size(), 0);

    // Timeout: slot 1 never signals done
    resetn = 1'b0;
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("error_cleared_by_reset", error, 0);
    clear_counts();
    never_done = 3'b010;
    run_frame(3'b111, 0, 0, cyc);
    check("timeout_latency", cyc, 41);
    check("timeout_en0_cycles", en_cycles[0], 6);
    check("timeout_en1_cycles", en_cycles[1], 16);
    check("timeout_en2_cycles", en_cycles[2], 6);
    check("timeout_error", error, 1);
    @(negedge clk);
    check("timeout_queue_drained", exp_q.size(), 0);
    never_done = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
